alu_pipe_nbit: RTL

//  Parametrised, pipelined N-bit ALU with valid/ready handshakes on input and output.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_pipe_nbit_if.sv | 40 ++++
 rtl/alu_core_nbit.sv | 57 +++++
 rtl/alu_pipe_nbit.sv | 113 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag bit positions for the pipelined N-bit ALU.
// The flag indices are only used when ALU_FLAGS_EN is defined.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_OP_PASS = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_NOT  = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SHL  = 3'b111;

    // Flags are packed {N,Z,C,V}, MSB first.
    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_pipe_nbit_if.sv
// Operand/result valid-ready bus of the pipelined ALU.
// The flags signal exists only when ALU_FLAGS_EN is defined.
interface alu_pipe_nbit_if
    import alu_pkg::*;
#(
    parameter int W = 32
) ();

    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        a;
    logic [W-1:0]        b;
    logic                c_in;
    logic [ALU_OP_W-1:0] alop;
    logic                out_valid;
    logic                out_ready;
    logic [W:0]          result;
`ifdef ALU_FLAGS_EN
    logic [FLAG_W-1:0]   flags;

    modport master (
        output in_valid, a, b, c_in, alop, out_ready,
        input  in_ready, out_valid, result, flags
    );
    modport slave (
        input  in_valid, a, b, c_in, alop, out_ready,
        output in_ready, out_valid, result, flags
    );
`else
    modport master (
        output in_valid, a, b, c_in, alop, out_ready,
        input  in_ready, out_valid, result
    );
    modport slave (
        input  in_valid, a, b, c_in, alop, out_ready,
        output in_ready, out_valid, result
    );
`endif

endinterface

// File: rtl/alu_core_nbit.sv
// Purely combinational N-bit ALU evaluation; bit W carries carry/borrow for ADD/SUB.
// Status flags {N,Z,C,V} are generated only when ALU_FLAGS_EN is defined.
module alu_core_nbit
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    input  logic                c_in,
    input  logic [ALU_OP_W-1:0] alop,
`ifdef ALU_FLAGS_EN
    output logic [FLAG_W-1:0]   flags,
`endif
    output logic [W:0]          result
);

    localparam int SH_W = $clog2(W);

    always_comb begin
        result = '0;
        case (alop)
            ALU_OP_PASS: result = {1'b0, a};
            ALU_OP_NOT:  result = {1'b0, ~a};
            ALU_OP_XOR:  result = {1'b0, a ^ b};
            ALU_OP_AND:  result = {1'b0, a & b};
            ALU_OP_OR:   result = {1'b0, a | b};
            ALU_OP_SUB:  result = {1'b0, a} - {1'b0, b};
            ALU_OP_ADD:  result = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
            ALU_OP_SHL:  result = {1'b0, a << b[SH_W-1:0]};
            default:     result = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic ovf;

    // Two's-complement overflow: operand signs that should agree do, but the sum's sign differs.
    always_comb begin
        ovf = 1'b0;
        case (alop)
            ALU_OP_ADD: ovf = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
            ALU_OP_SUB: ovf = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1]);
            default:    ovf = 1'b0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[W-1];
        flags[FLAG_Z] = (result[W-1:0] == '0);
        flags[FLAG_C] = result[W];
        flags[FLAG_V] = ovf;
    end
`endif

endmodule

// File: rtl/alu_pipe_nbit.sv
// Pipelined N-bit ALU with valid/ready on both sides; STAGES=2 adds an operand register.
// Optional registered status flags are enabled by defining ALU_FLAGS_EN.
module alu_pipe_nbit
    import alu_pkg::*;
#(
    parameter int W      = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_pipe_nbit_if.slave   bus
);

    logic [W-1:0]        core_a;
    logic [W-1:0]        core_b;
    logic                core_c;
    logic [ALU_OP_W-1:0] core_op;
    logic                core_vld;
    logic [W:0]          core_res;
    logic                in_ready_w;
    logic                load_p1;
    logic                vld_p1;
    logic [W:0]          res_p1;

    // The result stage may load whenever it is empty or its beat leaves this cycle.
    assign load_p1 = !vld_p1 || bus.out_ready;

    generate
        if (STAGES == 2) begin : g_two
            logic                vld_p0;
            logic [W-1:0]        a_p0;
            logic [W-1:0]        b_p0;
            logic                c_p0;
            logic [ALU_OP_W-1:0] op_p0;

            assign in_ready_w = !vld_p0 || load_p1;

            // Stage p0: operand register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p0 <= 1'b0;
                end else if (in_ready_w) begin
                    vld_p0 <= bus.in_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (bus.in_valid && in_ready_w) begin
                    a_p0  <= bus.a;
                    b_p0  <= bus.b;
                    c_p0  <= bus.c_in;
                    op_p0 <= bus.alop;
                end
            end

            assign core_a   = a_p0;
            assign core_b   = b_p0;
            assign core_c   = c_p0;
            assign core_op  = op_p0;
            assign core_vld = vld_p0;
        end else begin : g_one
            assign in_ready_w = load_p1;
            assign core_a     = bus.a;
            assign core_b     = bus.b;
            assign core_c     = bus.c_in;
            assign core_op    = bus.alop;
            assign core_vld   = bus.in_valid;
        end
    endgenerate

`ifdef ALU_FLAGS_EN
    logic [FLAG_W-1:0] core_flg;
    logic [FLAG_W-1:0] flg_p1;
`endif

    alu_core_nbit #(.W(W)) u_core (
        .a      (core_a),
        .b      (core_b),
        .c_in   (core_c),
        .alop   (core_op),
`ifdef ALU_FLAGS_EN
        .flags  (core_flg),
`endif
        .result (core_res)
    );

    // Stage p1: result register; result and flags are cleared so reset shows zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            res_p1 <= '0;
`ifdef ALU_FLAGS_EN
            flg_p1 <= '0;
`endif
        end else if (load_p1) begin
            vld_p1 <= core_vld;
            if (core_vld) begin
                res_p1 <= core_res;
`ifdef ALU_FLAGS_EN
                flg_p1 <= core_flg;
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = vld_p1;
    assign bus.result    = res_p1;
`ifdef ALU_FLAGS_EN
    assign bus.flags     = flg_p1;
`endif

endmodule
